// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared types and size helpers for the edge frame sequencer
package edge_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    // Each valid-mode window shrinks the frame by its radius on every side.
    function automatic int out_size(input int w, input int h,
                                    input int r_gauss, input int r_sobel);
        return (w - 2*r_gauss - 2*r_sobel) * (h - 2*r_gauss - 2*r_sobel);
    endfunction

endpackage

// File: rtl/seq_addr_counter.sv
// rtl/seq_addr_counter.sv - loadable up-counter with enable and terminal flag
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (count -> 0)
//   load, load_val synchronous load, priority over en
//   en             increment by one
//   count          current value
//   terminal       count equals TERM
module seq_addr_counter #(
    parameter int CW   = 8,
    parameter int TERM = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          terminal
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == CW'(TERM));

endmodule

// File: rtl/edge_frame_sequencer.sv
// rtl/edge_frame_sequencer.sv - frame feed / result capture controller for the Gauss->Sobel pipeline
//
// Optional feature macro: SEQ_TIMEOUT_EN (DRAIN watchdog driving err).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, hold, abort         frame control
//   rd_en, rd_addr, rd_data    synchronous-read frame memory (data 1 cycle after rd_en)
//   write, input_serial        pixel stream into the Gauss window buffer
//   pipe_valid, pipe_pix       Sobel results coming back
//   res_we, res_addr, res_data result memory write port
//   busy, done, err            status (busy in FEED/DRAIN, done pulse, sticky timeout)
module edge_frame_sequencer
    import edge_pkg::*;
#(
    parameter int  WIDTH       = 512,
    parameter int  HEIGHT      = 512,
    parameter int  R_GAUSS     = 2,
    parameter int  R_SOBEL     = 1,
    parameter int  TIMEOUT_CYC = 1024,
    localparam int IN_SIZE     = WIDTH * HEIGHT,
    localparam int OUT_SIZE    = out_size(WIDTH, HEIGHT, R_GAUSS, R_SOBEL),
    localparam int IN_AW       = $clog2(IN_SIZE),
    localparam int OUT_AW      = $clog2(OUT_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    output logic              rd_en,
    output logic [IN_AW-1:0]  rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              write,
    output logic [PIX_W-1:0]  input_serial,
    input  logic              pipe_valid,
    input  logic [PIX_W-1:0]  pipe_pix,
    output logic              res_we,
    output logic [OUT_AW-1:0] res_addr,
    output logic [PIX_W-1:0]  res_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // The result counter needs one extra bit so it can hold OUT_SIZE itself
    // and saturate there, one past the last legal result address.
    localparam int OCW = $clog2(OUT_SIZE + 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic             start_acc;
    logic [IN_AW-1:0] rd_cnt;
    logic             rd_last;
    logic [OCW-1:0]   out_cnt;
    logic             out_full;
    logic             out_last;
    logic             write_q;
    logic             wd_expire;

    assign start_acc = (state == S_IDLE) && start && !abort;
    assign busy      = (state == S_FEED) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

    // Abort suppresses the read so no pixel is left pending for the next cycle.
    assign rd_en     = (state == S_FEED) && !hold && !abort;
    assign rd_addr   = rd_cnt;

    seq_addr_counter #(
        .CW   (IN_AW),
        .TERM (IN_SIZE - 1)
    ) u_rd_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_acc),
        .load_val ('0),
        .en       (rd_en),
        .count    (rd_cnt),
        .terminal (rd_last)
    );

    // Beats arriving once the result frame is complete are dropped.
    assign res_we   = busy && pipe_valid && !out_full;
    assign res_addr = out_cnt[OUT_AW-1:0];
    assign res_data = pipe_pix;
    assign out_last = res_we && (out_cnt == OCW'(OUT_SIZE - 1));

    seq_addr_counter #(
        .CW   (OCW),
        .TERM (OUT_SIZE)
    ) u_out_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_acc),
        .load_val ('0),
        .en       (res_we),
        .count    (out_cnt),
        .terminal (out_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
        end else begin
            write_q <= rd_en;
        end
    end

    assign write        = write_q;
    assign input_serial = write_q ? rd_data : '0;

`ifdef SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    logic [WDW-1:0] wd_cnt;
    logic           err_q;

    // Counts idle DRAIN cycles; any counted result restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if ((state != S_DRAIN) || res_we) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end

    assign wd_expire = (state == S_DRAIN) && !res_we && (wd_cnt == WDW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (wd_expire && !abort) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign wd_expire          = 1'b0;
    assign err                = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                if (rd_en && rd_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_full || out_last || wd_expire) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// tb/tb_edge_frame_sequencer.sv - self-checking bench for edge_frame_sequencer (8x8 frame)
module tb_edge_frame_sequencer;
    import edge_pkg::*;

    localparam int W      = 8;
    localparam int H      = 8;
    localparam int NPIX   = W * H;
    localparam int NOUT   = out_size(W, H, 2, 1);
    localparam int TO_CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic [7:0] rd_data = 8'd0;
    logic       write;
    logic [7:0] input_serial;
    logic       pipe_valid = 1'b0;
    logic [7:0] pipe_pix = 8'd0;
    logic       res_we;
    logic [1:0] res_addr;
    logic [7:0] res_data;
    logic       busy;
    logic       done;
    logic       err;

    edge_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .R_GAUSS(2), .R_SOBEL(1), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .write(write), .input_serial(input_serial),
        .pipe_valid(pipe_valid), .pipe_pix(pipe_pix),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_of(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= pix_of(int'(rd_addr));
    end

    typedef struct { int addr; int data; } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   exp_rd, wcount, dcount, done_cyc, first_rd, first_wr, last_wr;
    logic [7:0] exp_pix[$];
    res_t exp_res[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_sb();
        exp_rd = 0; wcount = 0; dcount = 0; done_cyc = -1;
        first_rd = -1; first_wr = -1; last_wr = -1;
        exp_pix.delete();
        exp_res.delete();
        cyc = 0;
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                chk("rd_addr_order", int'(rd_addr), exp_rd);
                exp_pix.push_back(pix_of(exp_rd));
                exp_rd++;
            end
            if (write) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                wcount++;
                if (exp_pix.size() == 0) chk("write_unexpected", 1, 0);
                else chk("input_serial", int'(input_serial), int'(exp_pix.pop_front()));
            end
            if (res_we) begin
                if (exp_res.size() == 0) begin
                    chk("res_we_unexpected", 1, 0);
                end else begin
                    res_t r;
                    r = exp_res.pop_front();
                    chk("res_addr", int'(res_addr), r.addr);
                    chk("res_data", int'(res_data), r.data);
                end
            end
            if (done) begin
                dcount++;
                done_cyc = cyc;
            end
        end
    end

    typedef struct {
        int hold_lo; int hold_hi; int start2; int beat_c; int extra;
    } vec_t;

    vec_t vecs[4];

    task automatic run_frame(input vec_t v);
        int hl, drain_c, done_exp;
        hl = (v.hold_lo > 0) ? (v.hold_hi - v.hold_lo + 1) : 0;
        drain_c = 65 + hl;
        done_exp = (v.beat_c + 4 > drain_c + 1) ? v.beat_c + 4 : drain_c + 1;
        clear_sb();
        mon_en = 1'b1;
        for (int c = 0; c < 100; c++) begin
            start = (c == 0) || (c == v.start2);
            hold = (v.hold_lo > 0) && (c >= v.hold_lo) && (c <= v.hold_hi);
            pipe_valid = (c == 0) || ((c >= v.beat_c) && (c < v.beat_c + 4 + v.extra));
            pipe_pix = 8'(c * 13 + 5);
            if ((c >= v.beat_c) && (c < v.beat_c + 4)) begin
                res_t r;
                r.addr = c - v.beat_c;
                r.data = int'(pipe_pix);
                exp_res.push_back(r);
            end
            tick();
        end
        start = 1'b0; hold = 1'b0; pipe_valid = 1'b0;
        mon_en = 1'b0;
        chk("write_count", wcount, NPIX);
        chk("reads_issued", exp_rd, NPIX);
        chk("first_rd_cycle", first_rd, 1);
        chk("first_wr_cycle", first_wr, 2);
        chk("last_wr_cycle", last_wr, 65 + hl);
        chk("done_count", dcount, 1);
        chk("done_cycle", done_cyc, done_exp);
        chk("res_left", exp_res.size(), 0);
        chk("pix_left", exp_pix.size(), 0);
        chk("busy_after", int'(busy), 0);
        chk("err_after", int'(err), 0);
    endtask

    initial begin
        vecs[0] = '{hold_lo: 0,  hold_hi: 0,  start2: -1, beat_c: 20, extra: 2};
        vecs[1] = '{hold_lo: 10, hold_hi: 14, start2: 5,  beat_c: 20, extra: 0};
        vecs[2] = '{hold_lo: 0,  hold_hi: 0,  start2: -1, beat_c: 80, extra: 2};
        vecs[3] = '{hold_lo: 30, hold_hi: 31, start2: 40, beat_c: 66, extra: 0};

        // Reset state
        pipe_valid = 1'b1;
        #12;
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_write", int'(write), 0);
        chk("rst_input_serial", int'(input_serial), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_res_we", int'(res_we), 0);
        pipe_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i]);
            tick(); tick();
        end

        // Abort mid-FEED
        clear_sb();
        mon_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0);
            abort = (c == 30);
            tick();
            if (c == 30) chk("abort_busy", int'(busy), 0);
        end
        abort = 1'b0;
        mon_en = 1'b0;
        chk("abort_writes", wcount, 29);
        chk("abort_done", dcount, 0);
        chk("abort_pix_left", exp_pix.size(), 0);
        run_frame(vecs[0]);
        tick();

        // Asynchronous reset mid-FEED
        clear_sb();
        for (int c = 0; c < 20; c++) begin
            start = (c == 0);
            tick();
        end
        start = 1'b0;
        pipe_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_en", int'(rd_en), 0);
        chk("arst_rd_addr", int'(rd_addr), 0);
        chk("arst_write", int'(write), 0);
        chk("arst_input_serial", int'(input_serial), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_res_we", int'(res_we), 0);
        pipe_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Drain with no results at all
        clear_sb();
        mon_en = 1'b1;
        for (int c = 0; c < 120; c++) begin
            start = (c == 0);
            tick();
        end
        mon_en = 1'b0;
        chk("starve_writes", wcount, NPIX);
`ifdef SEQ_TIMEOUT_EN
        chk("timeout_done_count", dcount, 1);
        chk("timeout_done_cycle", done_cyc, 65 + TO_CYC);
        chk("timeout_err", int'(err), 1);
        chk("timeout_busy", int'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_cleared", int'(err), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`else
        chk("starve_done_count", dcount, 0);
        chk("starve_busy", int'(busy), 1);
        chk("starve_err", int'(err), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
        chk("final_busy", int'(busy), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
